stim_gen_mc: RTL and testbench
==============================

Name: stim_gen_mc

Overview:
Multi-channel successor to the single-channel stimulus generator. One shared free-running counter clocked by the 100 MHz system clock drives NUM_CH independent channels. Each channel produces:
- a periodic stim-switch drive pulse, with per-channel rate, continuous or burst mode, and a burst done/busy handshake;
- a glitch-free PWM DAC level output.

Sits between the slow-control register file and the stim switch/DAC pins.

Parameters:
NUM_CH, 4, number of independent stimulus channels
CNT_W, 19, shared counter width; rate 0 period = 2^CNT_W cycles
MIN_EXP, 12, smallest period exponent; period never below 2^MIN_EXP cycles
PWM_W, 8, PWM resolution in bits; PWM frame = 2^PWM_W cycles; PWM_W <= MIN_EXP
PULSE_LEN, 4, drive low-time per event in cycles; 1 <= PULSE_LEN < 2^MIN_EXP
BURST_W, 16, width of burst length field

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
enable  in  NUM_CH  per-channel enable
rate  in  4*NUM_CH  per-channel rate code, channel i at [4i+3:4i]
level  in  PWM_W*NUM_CH  per-channel PWM level
burst_mode  in  NUM_CH  0 = continuous, 1 = burst
burst_len  in  BURST_W*NUM_CH  pulses per burst
start  in  NUM_CH  single-cycle burst start strobe
stim_drive  out  NUM_CH  switch drive: high idle, low during event pulse
stim_dac  out  NUM_CH  PWM DAC output
busy  out  NUM_CH  burst in progress
done  out  NUM_CH  single-cycle burst-complete strobe

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - counter = 0;
  - all outputs 0;
  - burst state IDLE;
  - latched levels 0.
- Shared counter: increments every cycle, wraps 2^CNT_W-1 -> 0.
- Rate decode: exponent e = CNT_W - rate, clamped to e >= MIN_EXP (rate > CNT_W-MIN_EXP behaves as CNT_W-MIN_EXP). tick_i = counter[e-1:0] all ones. Rate changes take effect on the next tick; no reset of the counter.
- Pulse generation:
  - Tick in cycle t, channel firing: stim_drive low from cycle t+1 through t+PULSE_LEN, high again at t+PULSE_LEN+1.
  - A channel fires iff enable=1 and (burst_mode=0, or state ACTIVE).
  - Ticks never overlap a pulse, by the PULSE_LEN constraint.
- Enable: stim_drive is registered as enable & ~pulse_active. enable=0 forces stim_drive low on the next cycle and clears any in-progress pulse.
- Burst FSM per channel, states IDLE, ACTIVE, DONE:
  - IDLE: start=1 & burst_mode=1 & enable=1 -> latch burst_len into remaining.
    - remaining 0 -> DONE.
    - else -> ACTIVE, busy=1.
  - ACTIVE: each fired tick decrements remaining. When the last pulse's drive returns high -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
  - start while ACTIVE/DONE is ignored.
  - enable=0, or burst_mode=0, while ACTIVE: abort to IDLE, busy=0, no done.
- PWM per channel:
  - level sampled into level_q when counter[PWM_W-1:0]==0, so there is no mid-frame glitch.
  - stim_dac is registered. In each frame it goes high the cycle after phase==0 and low the cycle after phase==level_q; the level compare takes priority.
  - Duty = level_q/2^PWM_W; level 0 gives constant 0.
  - stim_dac is independent of enable and burst state.

Decomposition:
- Shared package stim_pkg holds:
  - burst state enum (IDLE, ACTIVE, DONE);
  - RATE_W=4 constant;
  - a function clamp_exp(rate, CNT_W, MIN_EXP).
- One sub-module stim_chan holds the per-channel rate decode, pulse timer, burst FSM and PWM. It takes the shared counter as an input and is instantiated NUM_CH times in a generate loop.
- The top level holds the counter and port slicing.

Test Plan:
- Continuous mode, rate=7, enable=1, PULSE_LEN=4: stim_drive low exactly 4 cycles every 4096 cycles. First low cycle is 4096 cycles after reset release: the counter reaches 4095 at cycle 4095, drive is low at 4096.
- rate=15 on ch1 with rate=7 on ch0: both channels identical period 4096 (clamp). rate=0: period 524288.
- level=64: stim_dac high 64 of every 256 cycles. level changed 64->192 mid-frame: the current frame keeps 64-cycle duty, the next frame gives 192. level=0: stim_dac constant 0.
- Burst mode, burst_len=3, start pulse:
  - busy=1 next cycle;
  - exactly 3 drive pulses on subsequent ticks;
  - done=1 single cycle when the 3rd pulse ends, busy=0;
  - no further pulses.
  - burst_len=0: done 1 cycle after DONE entry, no pulses.
- Mid-burst disturbances:
  - enable deasserted after 1 of 5 pulses: busy drops, done never asserts, drive low.
  - start asserted again during ACTIVE: ignored, pulse count unchanged.
- rst asserted mid-pulse and mid-burst: next cycle all outputs 0, counter 0. After release, behaviour repeats from scenario 1 timing.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared types and helpers for the multi-channel stimulus generator.
package stim_pkg;

    localparam int RATE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } burst_state_e;

    // Period exponent for a rate code; fast codes saturate at the minimum period.
    function automatic int clamp_exp(
        input logic [RATE_W-1:0] rate,
        input int                cnt_w,
        input int                min_exp
    );
        int e;
        if (int'(rate) > cnt_w - min_exp) begin
            e = min_exp;
        end else begin
            e = cnt_w - int'(rate);
        end
        return e;
    endfunction

endpackage

// File: rtl/stim_chan.sv
// One stimulus channel: rate tick decode, drive pulse timer, burst FSM and PWM DAC.
//   state     | meaning
//   ST_IDLE   | waiting for a burst start strobe (continuous mode fires from here)
//   ST_ACTIVE | burst running, busy high, fired ticks consume the remaining count
//   ST_DONE   | last burst pulse has ended, done high for this single cycle
module stim_chan
    import stim_pkg::*;
#(
    parameter int CNT_W     = 19,
    parameter int MIN_EXP   = 12,
    parameter int PWM_W     = 8,
    parameter int PULSE_LEN = 4,
    parameter int BURST_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   count,
    input  logic               enable,
    input  logic [RATE_W-1:0]  rate,
    input  logic [PWM_W-1:0]   level,
    input  logic               burst_mode,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               start,
    output logic               stim_drive,
    output logic               stim_dac,
    output logic               busy,
    output logic               done
);

    localparam int              PL_W        = $clog2(PULSE_LEN + 1);
    localparam logic [PL_W-1:0] PULSE_LEN_C = PL_W'(PULSE_LEN);

    int                 tick_exp;
    logic [CNT_W-1:0]   tick_mask;
    logic               tick;
    logic               fire;
    burst_state_e       state;
    burst_state_e       state_nxt;
    logic [BURST_W-1:0] remaining;
    logic [BURST_W-1:0] remaining_nxt;
    logic [PL_W-1:0]    pulse_cnt;
    logic [PL_W-1:0]    pulse_nxt;
    logic [PWM_W-1:0]   level_q;
    logic [PWM_W-1:0]   phase;
    logic [PWM_W-1:0]   level_cmp;

    always_comb begin
        tick_exp = clamp_exp(rate, CNT_W, MIN_EXP);
        for (int b = 0; b < CNT_W; b++) begin
            tick_mask[b] = (b < tick_exp);
        end
        tick = ((count & tick_mask) == tick_mask);
    end

    // In burst mode only an active burst with pulses left may fire.
    assign fire = tick && enable &&
                  (!burst_mode || (state == ST_ACTIVE && remaining != '0));

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            ST_IDLE: begin
                if (start && burst_mode && enable) begin
                    remaining_nxt = burst_len;
                    state_nxt     = (burst_len == '0) ? ST_DONE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable || !burst_mode) begin
                    state_nxt = ST_IDLE;
                end else begin
                    if (fire) begin
                        remaining_nxt = remaining - BURST_W'(1);
                    end
                    // Finish as the last pulse's drive returns high.
                    if (remaining == '0 && pulse_cnt == PL_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pulse_nxt = '0;
        if (!enable) begin
            pulse_nxt = '0;
        end else if (fire) begin
            pulse_nxt = PULSE_LEN_C;
        end else if (pulse_cnt != '0) begin
            pulse_nxt = pulse_cnt - PL_W'(1);
        end
    end

    assign phase = count[PWM_W-1:0];
    // At phase 0 the frame's new level is compared so level 0 stays flat.
    assign level_cmp = (phase == '0) ? level : level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            pulse_cnt  <= '0;
            stim_drive <= 1'b0;
            level_q    <= '0;
            stim_dac   <= 1'b0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            pulse_cnt  <= pulse_nxt;
            stim_drive <= enable && (pulse_nxt == '0);
            if (phase == '0) begin
                level_q <= level;
            end
            if (phase == level_cmp) begin
                stim_dac <= 1'b0;
            end else if (phase == '0) begin
                stim_dac <= 1'b1;
            end
        end
    end

    assign busy = (state == ST_ACTIVE);
    assign done = (state == ST_DONE);

endmodule

// File: rtl/stim_gen_mc.sv
// Multi-channel stimulus generator: one shared free-running counter feeding
// NUM_CH independent drive-pulse / PWM channels.
module stim_gen_mc
    import stim_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 19,
    parameter int MIN_EXP   = 12,
    parameter int PWM_W     = 8,
    parameter int PULSE_LEN = 4,
    parameter int BURST_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [RATE_W*NUM_CH-1:0]  rate,
    input  logic [PWM_W*NUM_CH-1:0]   level,
    input  logic [NUM_CH-1:0]         burst_mode,
    input  logic [BURST_W*NUM_CH-1:0] burst_len,
    input  logic [NUM_CH-1:0]         start,
    output logic [NUM_CH-1:0]         stim_drive,
    output logic [NUM_CH-1:0]         stim_dac,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        stim_chan #(
            .CNT_W     (CNT_W),
            .MIN_EXP   (MIN_EXP),
            .PWM_W     (PWM_W),
            .PULSE_LEN (PULSE_LEN),
            .BURST_W   (BURST_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .count      (count),
            .enable     (enable[i]),
            .rate       (rate[RATE_W*i +: RATE_W]),
            .level      (level[PWM_W*i +: PWM_W]),
            .burst_mode (burst_mode[i]),
            .burst_len  (burst_len[BURST_W*i +: BURST_W]),
            .start      (start[i]),
            .stim_drive (stim_drive[i]),
            .stim_dac   (stim_dac[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end

endmodule

// File: tb/tb_stim_gen_mc.sv
// Directed bench for stim_gen_mc; cycle numbers below equal the DUT counter value.
module tb_stim_gen_mc;

    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 19;
    localparam int MIN_EXP   = 12;
    localparam int PWM_W     = 8;
    localparam int PULSE_LEN = 4;
    localparam int BURST_W   = 16;

    logic                      clk;
    logic                      rst;
    logic [NUM_CH-1:0]         enable;
    logic [4*NUM_CH-1:0]       rate;
    logic [PWM_W*NUM_CH-1:0]   level;
    logic [NUM_CH-1:0]         burst_mode;
    logic [BURST_W*NUM_CH-1:0] burst_len;
    logic [NUM_CH-1:0]         start;
    logic [NUM_CH-1:0]         stim_drive;
    logic [NUM_CH-1:0]         stim_dac;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH-1:0]         done;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int pulses [NUM_CH];
    int lows   [NUM_CH];
    int dones  [NUM_CH];
    int dac_hi [NUM_CH];
    logic [NUM_CH-1:0] prev_drive;

    stim_gen_mc #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .MIN_EXP   (MIN_EXP),
        .PWM_W     (PWM_W),
        .PULSE_LEN (PULSE_LEN),
        .BURST_W   (BURST_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .rate       (rate),
        .level      (level),
        .burst_mode (burst_mode),
        .burst_len  (burst_len),
        .start      (start),
        .stim_drive (stim_drive),
        .stim_dac   (stim_dac),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < NUM_CH; c++) begin
            pulses[c] = 0;
            lows[c]   = 0;
            dones[c]  = 0;
            dac_hi[c] = 0;
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (prev_drive[c] && !stim_drive[c]) pulses[c]++;
                if (!stim_drive[c]) lows[c]++;
                if (done[c]) dones[c]++;
                if (stim_dac[c]) dac_hi[c]++;
            end
            prev_drive = stim_drive;
        end
    endtask

    task automatic go_cyc(input int n);
        step(n - cyc);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        enable     = 4'b1111;
        rate       = {4'd7, 4'd0, 4'd15, 4'd7};
        level      = {8'd255, 8'd128, 8'd0, 8'd64};
        burst_mode = 4'b1000;
        burst_len  = {16'd3, 16'd0, 16'd0, 16'd0};
        start      = '0;
        prev_drive = '0;
        clr();
        repeat (3) @(negedge clk);
        check("rst_drive", stim_drive, 0);
        check("rst_dac", stim_dac, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        step(1);
        check("drive_idle", stim_drive, 4'b1111);
        go_cyc(256);
        check("dac_l64", dac_hi[0], 64);
        check("dac_l0", dac_hi[1], 0);
        check("dac_l128", dac_hi[2], 128);
        check("dac_l255", dac_hi[3], 255);

        clr();
        go_cyc(356);
        level[7:0] = 8'd192;
        go_cyc(512);
        check("dac_keep64", dac_hi[0], 64);
        clr();
        go_cyc(768);
        check("dac_new192", dac_hi[0], 192);
        check("dac_still0", dac_hi[1], 0);

        clr();
        go_cyc(1000);
        check("busy_pre", busy[3], 0);
        start[3] = 1'b1;
        go_cyc(1001);
        start[3] = 1'b0;
        check("busy_start", busy[3], 1);
        go_cyc(2000);
        start[3] = 1'b1;
        go_cyc(2001);
        start[3] = 1'b0;

        go_cyc(4095);
        check("drv_4095", stim_drive, 4'b1111);
        go_cyc(4096);
        check("drv_4096", stim_drive, 4'b0100);
        go_cyc(4099);
        check("drv_4099", stim_drive, 4'b0100);
        go_cyc(4100);
        check("drv_4100", stim_drive, 4'b1111);

        go_cyc(12291);
        check("brst_busy_last", busy[3], 1);
        check("brst_done_early", done[3], 0);
        go_cyc(12292);
        check("brst_done", done[3], 1);
        check("brst_busy_end", busy[3], 0);
        check("brst_drv_high", stim_drive[3], 1);
        go_cyc(12293);
        check("brst_done_1cyc", done[3], 0);

        go_cyc(17000);
        check("cont_pulses_r7", pulses[0], 4);
        check("cont_pulses_r15", pulses[1], 4);
        check("cont_pulses_r0", pulses[2], 0);
        check("brst_pulses3", pulses[3], 3);
        check("cont_lows_r7", lows[0], 16);
        check("brst_lows3", lows[3], 12);
        check("brst_done_cnt", dones[3], 1);
        check("cont_no_done", dones[0], 0);

        burst_len[63:48] = 16'd0;
        start[3] = 1'b1;
        go_cyc(17001);
        start[3] = 1'b0;
        check("len0_done", done[3], 1);
        check("len0_busy", busy[3], 0);
        go_cyc(17002);
        check("len0_done_1cyc", done[3], 0);

        clr();
        burst_len[63:48] = 16'd5;
        go_cyc(17100);
        start[3] = 1'b1;
        go_cyc(17101);
        start[3] = 1'b0;
        check("abort_busy_on", busy[3], 1);
        go_cyc(21000);
        enable[3] = 1'b0;
        go_cyc(21001);
        check("abort_busy_off", busy[3], 0);
        check("abort_drv_low", stim_drive[3], 0);
        go_cyc(30000);
        check("abort_pulses", pulses[3], 2);
        check("abort_no_done", dones[3], 0);
        check("abort_drv_stay", stim_drive[3], 0);

        enable[3] = 1'b1;
        burst_len[63:48] = 16'd3;
        start[3] = 1'b1;
        go_cyc(30001);
        start[3] = 1'b0;
        check("rb_busy", busy[3], 1);
        go_cyc(32769);
        check("rb_mid_pulse", stim_drive, 4'b0100);

        rst = 1'b1;
        step(1);
        check("mid_rst_drive", stim_drive, 0);
        check("mid_rst_dac", stim_dac, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        clr();
        go_cyc(256);
        check("rr_dac_l192", dac_hi[0], 192);
        go_cyc(4095);
        check("rr_drv_4095", stim_drive, 4'b1111);
        go_cyc(4096);
        check("rr_drv_4096", stim_drive, 4'b1100);
        check("rr_busy", busy[3], 0);
        go_cyc(4100);
        check("rr_drv_4100", stim_drive, 4'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
